// File: rtl/stable_counter_unit_pkg.sv
// rtl/stable_counter_unit_pkg.sv - op codes and result-select decode for the rdcnt execute unit
package stable_counter_unit_pkg;

  localparam logic [7:0] OP_RDCNTVL = 8'h01;
  localparam logic [7:0] OP_RDCNTVH = 8'h02;
  localparam logic [7:0] OP_RDCNTID = 8'h03;
  localparam logic [7:0] OP_INVALID = 8'hFF;

  localparam int unsigned PS_W = 8;

  typedef enum logic [1:0] {
    SEL_VL  = 2'd0,
    SEL_VH  = 2'd1,
    SEL_ID  = 2'd2,
    SEL_BAD = 2'd3
  } rd_sel_e;

  // Anything outside the three rdcnt ops is reported as an error response.
  function automatic rd_sel_e decode_op(input logic [7:0] op);
    case (op)
      OP_RDCNTVL: decode_op = SEL_VL;
      OP_RDCNTVH: decode_op = SEL_VH;
      OP_RDCNTID: decode_op = SEL_ID;
      default:    decode_op = SEL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/stable_counter_unit_counter.sv
// rtl/stable_counter_unit_counter.sv - prescaler plus 64-bit free-running stable counter
module stable_counter
  import stable_counter_unit_pkg::*;
#(
  parameter logic [63:0] CNT_INIT = 64'h0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [63:0] cnt_value
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [63:0]     cnt_q, cnt_d;

  // Advance the prescaler; bump the counter (wrapping silently) on its last step.
  always_comb begin
    ps_d  = ps_q + 1'b1;
    cnt_d = cnt_q;
    if (ps_q == PS_LAST) begin
      ps_d  = '0;
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter and prescaler state, restarted from CNT_INIT on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ps_q  <= '0;
      cnt_q <= CNT_INIT;
    end else begin
      ps_q  <= ps_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_value = cnt_q;

endmodule

// File: rtl/stable_counter_unit.sv
// rtl/stable_counter_unit.sv - rdcnt execute unit: counter/TID reads through a one-entry response buffer
module stable_counter_unit
  import stable_counter_unit_pkg::*;
#(
  parameter logic [63:0] CNT_INIT = 64'h0,
  parameter int unsigned PRESCALE = 1,
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  input  logic        tid_we,
  input  logic [31:0] tid_wdata,
  output logic [31:0] tid_rdata,
  output logic [63:0] cnt_value
);

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] tid_q, tid_d;
  logic [63:0] cnt;
  logic        accept;
  logic [31:0] rd_value;
  logic        rd_bad;

  stable_counter #(
    .CNT_INIT (CNT_INIT),
    .PRESCALE (PRESCALE)
  ) u_counter (
    .clk       (clk),
    .resetn    (resetn),
    .cnt_value (cnt)
  );

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  // Select the result for the incoming op; RDCNTID sees a same-cycle TID write.
  always_comb begin
    rd_value = 32'h0;
    rd_bad   = 1'b0;
    case (decode_op(req_op))
      SEL_VL:  rd_value = cnt[31:0];
      SEL_VH:  rd_value = cnt[63:32];
      SEL_ID:  rd_value = tid_we ? tid_wdata : tid_q;
      default: rd_bad   = 1'b1;
    endcase
  end

  // Response buffer: reload on accept, drain on consume, otherwise hold steady.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    tid_d        = tid_we ? tid_wdata : tid_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_data_d  = rd_value;
      resp_rd_d    = req_rd;
      resp_err_d   = rd_bad;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Buffer and TID registers; reset drops any pending response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= 1'b0;
      tid_q        <= TID_INIT;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      tid_q        <= tid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;
  assign tid_rdata  = tid_q;
  assign cnt_value  = cnt;

endmodule

// File: tb/tb_stable_counter_unit.sv
// tb/tb_stable_counter_unit.sv - three differently-parameterised units driven by one directed stimulus table
module tb_stable_counter_unit;
  import stable_counter_unit_pkg::*;

  function automatic logic [63:0] init_of(input int k);
    case (k)
      0:       init_of = 64'h0000_0001_FFFF_FFFE;
      1:       init_of = 64'hFFFF_FFFF_FFFF_FFFF;
      default: init_of = 64'h0000_0000_0000_0100;
    endcase
  endfunction

  function automatic int ps_of(input int k);
    ps_of = (k == 2) ? 4 : 1;
  endfunction

  function automatic logic [31:0] tid_of(input int k);
    tid_of = (k == 1) ? 32'h1234_5678 : 32'h0;
  endfunction

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_op = 8'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_ready = 1'b1;
  logic        tid_we = 1'b0;
  logic [31:0] tid_wdata = 32'h0;

  logic        o_req_ready [3];
  logic        o_resp_valid[3];
  logic [31:0] o_resp_data [3];
  logic [4:0]  o_resp_rd   [3];
  logic        o_resp_err  [3];
  logic [31:0] o_tid_rdata [3];
  logic [63:0] o_cnt       [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    stable_counter_unit #(
      .CNT_INIT (init_of(g)),
      .PRESCALE (ps_of(g)),
      .TID_INIT (tid_of(g))
    ) u_dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (o_req_ready[g]),
      .req_op     (req_op),
      .req_rd     (req_rd),
      .resp_valid (o_resp_valid[g]),
      .resp_ready (resp_ready),
      .resp_data  (o_resp_data[g]),
      .resp_rd    (o_resp_rd[g]),
      .resp_err   (o_resp_err[g]),
      .tid_we     (tid_we),
      .tid_wdata  (tid_wdata),
      .tid_rdata  (o_tid_rdata[g]),
      .cnt_value  (o_cnt[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: counter is CNT_INIT + edges/PRESCALE; buffer holds the last accepted result.
  int          m_n = 0;
  logic        m_valid[3];
  logic [31:0] m_data [3];
  logic [4:0]  m_rd   [3];
  logic        m_err  [3];
  logic [31:0] m_tid  [3];

  function automatic logic [63:0] model_cnt(input int k, input int edges);
    model_cnt = init_of(k) + 64'(edges / ps_of(k));
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_n <= 0;
      for (int k = 0; k < 3; k++) begin
        m_valid[k] <= 1'b0;
        m_data[k]  <= 32'h0;
        m_rd[k]    <= 5'd0;
        m_err[k]   <= 1'b0;
        m_tid[k]   <= tid_of(k);
      end
    end else begin
      m_n <= m_n + 1;
      for (int k = 0; k < 3; k++) begin
        logic [63:0] c;
        c = model_cnt(k, m_n);
        if (req_valid && (!m_valid[k] || resp_ready)) begin
          m_valid[k] <= 1'b1;
          m_rd[k]    <= req_rd;
          m_err[k]   <= 1'b0;
          if (req_op == OP_RDCNTVL)      m_data[k] <= c[31:0];
          else if (req_op == OP_RDCNTVH) m_data[k] <= c[63:32];
          else if (req_op == OP_RDCNTID) m_data[k] <= tid_we ? tid_wdata : m_tid[k];
          else begin
            m_data[k] <= 32'h0;
            m_err[k]  <= 1'b1;
          end
        end else if (resp_ready) begin
          m_valid[k] <= 1'b0;
        end
        if (tid_we) m_tid[k] <= tid_wdata;
      end
    end
  end

  // Compare every cycle on the falling edge, plus hand-computed anchors.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("cnt_value", k, o_cnt[k], model_cnt(k, m_n));
      chk("resp_valid", k, 64'(o_resp_valid[k]), 64'(m_valid[k]));
      chk("req_ready", k, 64'(o_req_ready[k]), 64'(!m_valid[k] || resp_ready));
      chk("tid_rdata", k, 64'(o_tid_rdata[k]), 64'(m_tid[k]));
      if (m_valid[k]) begin
        chk("resp_data", k, 64'(o_resp_data[k]), 64'(m_data[k]));
        chk("resp_rd", k, 64'(o_resp_rd[k]), 64'(m_rd[k]));
        chk("resp_err", k, 64'(o_resp_err[k]), 64'(m_err[k]));
      end
      if (phase == 0 && !resetn) begin
        chk("reset_data", k, 64'(o_resp_data[k]), 64'h0);
        chk("reset_rd", k, 64'(o_resp_rd[k]), 64'h0);
        chk("reset_err", k, 64'(o_resp_err[k]), 64'h0);
      end
    end
    if (phase == 1) begin
      case (m_n)
        1: begin
          chk("lit_vl_first", 0, 64'(o_resp_data[0]), 64'hFFFF_FFFE);
          chk("lit_wrap_c0", 1, 64'(o_resp_data[1]), 64'hFFFF_FFFF);
        end
        2: begin
          chk("lit_vl_carry", 0, 64'(o_resp_data[0]), 64'hFFFF_FFFF);
          chk("lit_wrap_c1", 1, 64'(o_resp_data[1]), 64'h0);
        end
        3: chk("lit_vh_carry", 0, 64'(o_resp_data[0]), 64'h2);
        4: begin
          chk("lit_tid_bypass", 0, 64'(o_resp_data[0]), 64'hA5);
          chk("lit_tid_rdata", 0, 64'(o_tid_rdata[0]), 64'hA5);
        end
        5: begin
          chk("lit_inv_err", 0, 64'(o_resp_err[0]), 64'h1);
          chk("lit_inv_data", 0, 64'(o_resp_data[0]), 64'h0);
          chk("lit_inv_rd", 0, 64'(o_resp_rd[0]), 64'd7);
        end
        7, 8, 9: begin
          chk("lit_bp_ready", 0, 64'(o_req_ready[0]), 64'h0);
          chk("lit_bp_rd", 0, 64'(o_resp_rd[0]), 64'd8);
        end
        10: chk("lit_drain_rd9", 0, 64'(o_resp_rd[0]), 64'd9);
        11: chk("lit_drain_rd10", 0, 64'(o_resp_rd[0]), 64'd10);
        12: begin
          chk("lit_prescale4", 2, o_cnt[2], 64'h103);
          chk("lit_cnt12", 0, o_cnt[0], 64'h0000_0002_0000_000A);
          chk("lit_wrap12", 1, o_cnt[1], 64'hB);
        end
        15: chk("lit_tid_read", 0, 64'(o_resp_data[0]), 64'hDEAD_BEEF);
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic        rr;
    logic        twe;
    logic [31:0] twd;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, OP_RDCNTVL, 5'd1,  1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, OP_RDCNTVL, 5'd2,  1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, OP_RDCNTVH, 5'd3,  1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, OP_RDCNTID, 5'd4,  1'b1, 1'b1, 32'h0000_00A5};
    vecs[4]  = '{1'b1, OP_INVALID, 5'd7,  1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, OP_RDCNTVL, 5'd8,  1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, OP_RDCNTVH, 5'd9,  1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, OP_RDCNTVH, 5'd9,  1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, OP_RDCNTVH, 5'd9,  1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, OP_RDCNTVH, 5'd9,  1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, OP_RDCNTID, 5'd10, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, OP_RDCNTVL, 5'd0,  1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, OP_RDCNTVL, 5'd0,  1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, OP_RDCNTVL, 5'd0,  1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[14] = '{1'b1, OP_RDCNTID, 5'd11, 1'b1, 1'b0, 32'h0};
    vecs[15] = '{1'b1, OP_RDCNTVL, 5'd12, 1'b1, 1'b0, 32'h0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) begin
        resetn = 1'b1;
        phase  = 1;
      end
      req_valid  = vecs[i].v;
      req_op     = vecs[i].op;
      req_rd     = vecs[i].rd;
      resp_ready = vecs[i].rr;
      tid_we     = vecs[i].twe;
      tid_wdata  = vecs[i].twd;
    end

    // Leave a response pending under backpressure, then reset mid-flight.
    @(negedge clk);
    #1;
    req_valid  = 1'b1;
    req_op     = OP_RDCNTVL;
    req_rd     = 5'd3;
    resp_ready = 1'b0;
    tid_we     = 1'b0;
    @(negedge clk);
    #3;
    phase  = 2;
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midreset_valid", k, 64'(o_resp_valid[k]), 64'h0);
      chk("midreset_cnt", k, o_cnt[k], init_of(k));
    end
    @(negedge clk);
    #1;
    resetn     = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
